// File: rtl/sched_mbus.sv
// sched_mbus: p12 phase sequencer (fetch/exec/mem/writeback) and memory-bus controller.
// Bus phases stretch on mbus_ready wait states; a watchdog parks the core in ERR on a silent bus.
module sched_mbus #(
  parameter int WIDTH     = 32,
  parameter int ADDR_SIZE = 32,
  parameter int WAIT_MAX  = 15,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] pc,
  input  logic [ADDR_SIZE-1:0] ldst_addr,
  input  logic [WIDTH-1:0]     st_data,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic                 mem_en,
  output logic [ADDR_SIZE-1:0] mbus_aout,
  output logic [WIDTH-1:0]     mbus_dout,
  input  logic [WIDTH-1:0]     mbus_din,
  output logic                 mbus_ren,
  output logic                 mbus_wen,
  input  logic                 mbus_ready,
  output logic [WIDTH-1:0]     ic,
  output logic [WIDTH-1:0]     mr_data,
  output logic                 phf,
  output logic                 phe,
  output logic                 phm,
  output logic                 phw,
  output logic [2:0]           clk_stat,
  output logic                 bus_err
);
  typedef enum logic [2:0] {
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    ERR   = 3'd7
  } state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] ic_q, ic_d, mr_q, mr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       op_q, op_d;
  logic             timeout;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ic_q    <= '0;
      mr_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      ic_q    <= ic_d;
      mr_q    <= mr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
  // Saturating wait counter; the timeout fires on the wait cycle that reaches WAIT_MAX.
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign timeout = (WAIT_MAX != 0) && (cnt_inc == CNT_W'(WAIT_MAX));
  always_comb begin
    state_d   = state_q;
    ic_d      = ic_q;
    mr_d      = mr_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    mbus_aout = pc;
    mbus_ren  = 1'b0;
    mbus_wen  = 1'b0;
    case (state_q)
      FETCH: begin
        mbus_ren = 1'b1;
        if (mbus_ready) begin
          ic_d    = mbus_din;
          cnt_d   = '0;
          state_d = EXEC;
        end else begin
          cnt_d   = cnt_inc;
          state_d = timeout ? ERR : FETCH;
        end
      end
      EXEC: begin
        op_d    = {mem_rd & mem_en, mem_wr & mem_en & ~mem_rd};
        state_d = (mem_en & (mem_rd | mem_wr)) ? MEM : WB;
      end
      MEM: begin
        mbus_aout = ldst_addr;
        mbus_ren  = op_q[1];
        mbus_wen  = op_q[0];
        if (mbus_ready) begin
          mr_d    = op_q[1] ? mbus_din : mr_q;
          cnt_d   = '0;
          state_d = WB;
        end else begin
          cnt_d   = cnt_inc;
          state_d = timeout ? ERR : MEM;
        end
      end
      WB:      state_d = FETCH;
      default: state_d = state_q;
    endcase
  end
  assign mbus_dout = st_data;
  assign ic        = ic_q;
  assign mr_data   = mr_q;
  assign phf       = state_q == FETCH;
  assign phe       = state_q == EXEC;
  assign phm       = state_q == MEM;
  assign phw       = state_q == WB;
  assign clk_stat  = state_q;
  assign bus_err   = state_q == ERR;
endmodule

// File: tb/tb_sched_mbus.sv
// tb_sched_mbus: directed-vector bench for sched_mbus with hand-computed expectations.
module tb_sched_mbus;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, ldst_addr, st_data, mbus_din;
  logic        mem_rd, mem_wr, mem_en, mbus_ready;
  logic [31:0] mbus_aout, mbus_dout, ic, mr_data;
  logic        mbus_ren, mbus_wen, phf, phe, phm, phw, bus_err;
  logic [2:0]  clk_stat;
  int          vectors = 0;
  int          miscompares = 0;

  sched_mbus dut (
    .clk(clk), .reset(reset), .pc(pc), .ldst_addr(ldst_addr), .st_data(st_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_en(mem_en), .mbus_aout(mbus_aout),
    .mbus_dout(mbus_dout), .mbus_din(mbus_din), .mbus_ren(mbus_ren), .mbus_wen(mbus_wen),
    .mbus_ready(mbus_ready), .ic(ic), .mr_data(mr_data), .phf(phf), .phe(phe),
    .phm(phm), .phw(phw), .clk_stat(clk_stat), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pc = 32'h100; ldst_addr = 32'h2000; st_data = 32'h55AA55AA;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_en = 1'b0; mbus_ready = 1'b1; mbus_din = 32'h01234567;
    tick; tick;
    chk("rst_stat", 32'(clk_stat), 32'd1);
    chk("rst_ic", ic, 32'h0);
    chk("rst_mr", mr_data, 32'h0);
    chk("rst_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    // ALU instruction: 1,2,4,1
    #1;
    chk("alu_f_stat", 32'(clk_stat), 32'd1);
    chk("alu_f_ren", 32'(mbus_ren), 32'd1);
    chk("alu_f_aout", mbus_aout, 32'h100);
    chk("alu_f_ph", 32'({phf, phe, phm, phw}), 32'b1000);
    tick;
    chk("alu_e_stat", 32'(clk_stat), 32'd2);
    chk("alu_e_ic", ic, 32'h01234567);
    chk("alu_e_ren", 32'(mbus_ren), 32'd0);
    chk("alu_e_ph", 32'({phf, phe, phm, phw}), 32'b0100);
    tick;
    chk("alu_w_stat", 32'(clk_stat), 32'd4);
    chk("alu_w_ph", 32'({phf, phe, phm, phw}), 32'b0001);
    chk("alu_w_ren", 32'(mbus_ren), 32'd0);
    tick;
    chk("alu_f2_stat", 32'(clk_stat), 32'd1);
    // load: 1,2,3,4
    mem_rd = 1'b1; mem_en = 1'b1; mbus_din = 32'hDEADBEEF;
    tick;
    chk("ld_e_stat", 32'(clk_stat), 32'd2);
    tick;
    chk("ld_m_stat", 32'(clk_stat), 32'd3);
    chk("ld_m_aout", mbus_aout, 32'h2000);
    chk("ld_m_ren", 32'(mbus_ren), 32'd1);
    chk("ld_m_wen", 32'(mbus_wen), 32'd0);
    chk("ld_m_ph", 32'({phf, phe, phm, phw}), 32'b0010);
    tick;
    chk("ld_w_stat", 32'(clk_stat), 32'd4);
    chk("ld_w_mr", mr_data, 32'hDEADBEEF);
    mem_rd = 1'b0;
    tick;
    chk("ld_f_stat", 32'(clk_stat), 32'd1);
    // store with three wait states in MEM
    mem_wr = 1'b1; mbus_din = 32'h11111111;
    tick;
    chk("st_e_stat", 32'(clk_stat), 32'd2);
    mbus_ready = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("st_wait_stat", 32'(clk_stat), 32'd3);
      chk("st_wait_wen", 32'(mbus_wen), 32'd1);
      chk("st_wait_ren", 32'(mbus_ren), 32'd0);
      chk("st_wait_dout", mbus_dout, 32'h55AA55AA);
      tick;
    end
    mbus_ready = 1'b1;
    chk("st_m4_stat", 32'(clk_stat), 32'd3);
    chk("st_m4_wen", 32'(mbus_wen), 32'd1);
    tick;
    chk("st_w_stat", 32'(clk_stat), 32'd4);
    chk("st_w_mr", mr_data, 32'hDEADBEEF);
    tick;
    chk("st_f_stat", 32'(clk_stat), 32'd1);
    // store with condition false skips MEM
    mem_en = 1'b0;
    tick;
    chk("stn_e_wen", 32'(mbus_wen), 32'd0);
    tick;
    chk("stn_skip_stat", 32'(clk_stat), 32'd4);
    chk("stn_skip_wen", 32'(mbus_wen), 32'd0);
    chk("stn_skip_mr", mr_data, 32'hDEADBEEF);
    tick;
    // rd and wr both set: load wins
    mem_rd = 1'b1; mem_wr = 1'b1; mem_en = 1'b1; mbus_din = 32'hCAFEF00D;
    tick;
    tick;
    chk("rw_m_stat", 32'(clk_stat), 32'd3);
    chk("rw_m_ren", 32'(mbus_ren), 32'd1);
    chk("rw_m_wen", 32'(mbus_wen), 32'd0);
    tick;
    chk("rw_w_mr", mr_data, 32'hCAFEF00D);
    tick;
    // reset during a MEM store wait
    mem_rd = 1'b0;
    tick;
    mbus_ready = 1'b0;
    tick;
    chk("rw_mid_wen", 32'(mbus_wen), 32'd1);
    tick;
    chk("rw_mid2_wen", 32'(mbus_wen), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_wen", 32'(mbus_wen), 32'd0);
    chk("arst_stat", 32'(clk_stat), 32'd1);
    chk("arst_ic", ic, 32'h0);
    chk("arst_mr", mr_data, 32'h0);
    tick;
    reset = 1'b0; mem_wr = 1'b0; mem_en = 1'b0;
    #1;
    chk("arst_err", 32'(bus_err), 32'd0);
    // fetch timeout: 15 wait cycles then ERR
    for (int i = 0; i < 15; i++) begin
      chk("to_fetch_stat", 32'(clk_stat), 32'd1);
      tick;
    end
    chk("to_err_stat", 32'(clk_stat), 32'd7);
    chk("to_err_flag", 32'(bus_err), 32'd1);
    chk("to_err_strb", 32'({mbus_ren, mbus_wen}), 32'd0);
    chk("to_err_ph", 32'({phf, phe, phm, phw}), 32'd0);
    chk("to_err_aout", mbus_aout, 32'h100);
    mbus_ready = 1'b1;
    tick; tick; tick;
    chk("to_stick_stat", 32'(clk_stat), 32'd7);
    chk("to_stick_flag", 32'(bus_err), 32'd1);
    reset = 1'b1;
    #1;
    chk("to_rst_stat", 32'(clk_stat), 32'd1);
    chk("to_rst_flag", 32'(bus_err), 32'd0);
    tick;
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sched_mbus.md
Name: sched_mbus

Overview:
- Phase sequencer and memory-bus controller for the next-generation multi-cycle p12 core.
- Replaces the fixed 4-phase scheduler/bus glue with a variable-length sequence: fetch → exec → optional mem → writeback.
- Fetch and mem phases stretch on a bus ready handshake (wait states).
- A watchdog flags a bus that never responds. Fetched instruction word and load data are latched here for the core.

Parameters:
- WIDTH, 32, data bus and instruction width.
- ADDR_SIZE, 32, address bus width.
- WAIT_MAX, 15, maximum wait cycles allowed in one bus phase; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; WAIT_MAX must fit in CNT_W bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- pc  in  ADDR_SIZE  current program counter from core
- ldst_addr  in  ADDR_SIZE  load/store effective address from core
- st_data  in  WIDTH  store data from core
- mem_rd  in  1  current instruction is a load (sampled in EXEC)
- mem_wr  in  1  current instruction is a store (sampled in EXEC)
- mem_en  in  1  condition true; memory access allowed (sampled in EXEC)
- mbus_aout  out  ADDR_SIZE  bus address
- mbus_dout  out  WIDTH  bus write data
- mbus_din  in  WIDTH  bus read data
- mbus_ren  out  1  read strobe
- mbus_wen  out  1  write strobe
- mbus_ready  in  1  slave completes current access this cycle
- ic  out  WIDTH  latched instruction word
- mr_data  out  WIDTH  latched load data
- phf, phe, phm, phw  out  1 each  one-hot phase indicators
- clk_stat  out  3  state code
- bus_err  out  1  sticky timeout flag

Behaviour:
States and clk_stat codes: FETCH=1, EXEC=2, MEM=3, WB=4, ERR=7.
- Reset (async, any state): state=FETCH, ic=0, mr_data=0, bus_err=0, wait counter=0, mem-op latch=00.
- Phase outputs are decoded from state only: phf=FETCH, phe=EXEC, phm=MEM, phw=WB. All are 0 in ERR.
- mbus_dout=st_data at all times.

FETCH:
- mbus_aout=pc, mbus_ren=1, mbus_wen=0.
- If mbus_ready: ic<=mbus_din, counter<=0, next EXEC.
- Else counter increments. If WAIT_MAX≠0 and counter==WAIT_MAX: next ERR.
- Zero-wait fetch takes exactly 1 cycle.

EXEC (always 1 cycle):
- mbus_aout=pc, no strobes.
- Latch op<={mem_rd&mem_en, mem_wr&mem_en}.
- If mem_rd and mem_wr are both 1, treat as a load (rd wins).
- Next is MEM if either latched bit is 1, else WB (MEM is skipped).

MEM:
- mbus_aout=ldst_addr.
- mbus_ren=op.rd, mbus_wen=op.wr. Strobes are held constant through all wait cycles.
- On mbus_ready: if op.rd then mr_data<=mbus_din; counter<=0; next WB.
- Timeout rule is the same as FETCH.
- mr_data is unchanged by stores and by skipped MEM phases.

WB (always 1 cycle):
- mbus_aout=pc, no strobes, next FETCH.
- The core updates pc/registers on this phase.

ERR:
- bus_err=1, mbus_aout=pc, no strobes, phases all 0.
- Stays in ERR until reset.

Other rules:
- mbus_ready is ignored outside FETCH/MEM.
- The counter saturates at 2^CNT_W-1 when WAIT_MAX=0.
- Reset asserted mid-wait drops the strobes immediately (combinational from state).

Sequence lengths (zero wait states): ALU/branch instruction = 3 cycles; load/store = 4 cycles. Each wait cycle adds 1.

Test Plan:
- Reset, then pc=0x100 and mbus_ready=1 held with mbus_din=0x01234567, no mem ops → clk_stat sequence 1,2,4,1; ic=0x01234567; phm never asserted; mbus_ren high only in FETCH.
- Load with ldst_addr=0x2000, mbus_ready=1, din=0xDEADBEEF → 4-cycle sequence 1,2,3,4; in MEM aout=0x2000, ren=1; mr_data=0xDEADBEEF in WB.
- Store with mem_en=1, st_data=0x55AA55AA, mbus_ready low for 3 MEM cycles → MEM lasts 4 cycles, wen=1 and dout=0x55AA55AA held throughout, mr_data unchanged; store with mem_en=0 → MEM skipped, wen never 1.
- WAIT_MAX=15, mbus_ready held 0 in FETCH → ERR entered after 15 wait cycles, bus_err=1, clk_stat=7, all strobes/phases 0; stays until reset.
- Reset asserted during a MEM wait with wen=1 → wen drops in the same cycle; after release state=FETCH, ic=0, bus_err=0.
- mem_rd=mem_wr=1 with mem_en=1 → only ren asserted in MEM; load data captured.
